// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath widths, control-bus bit positions
// and memory access size encodings.
package mips_pkg;

   localparam int unsigned LEN       = 32;
   localparam int unsigned NB        = $clog2(LEN);
   localparam int unsigned MEM_DEPTH = 1024;
   localparam int unsigned ADDR_BITS = $clog2(MEM_DEPTH);
   localparam int unsigned LANES     = LEN / 8;

   localparam int unsigned MEM_BRANCH = 2;
   localparam int unsigned MEM_READ   = 1;
   localparam int unsigned MEM_WRITE  = 0;

   localparam int unsigned WB_REGWRITE = 1;
   localparam int unsigned WB_MEMTOREG = 0;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } mem_size_e;

   // Reserved size behaves as a word access.
   function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] low);
      case (size)
         SIZE_BYTE: is_misaligned = 1'b0;
         SIZE_HALF: is_misaligned = low[0];
         default:   is_misaligned = |low;
      endcase
   endfunction

endpackage

// File: rtl/memory_access_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory-access stage.
interface memory_access_if;
   import mips_pkg::*;

   logic [LEN-1:0] in_alu;
   logic [LEN-1:0] in_reg2;
   logic [NB-1:0]  in_write_reg;
   logic [LEN-1:0] in_pc_branch;
   logic           zero_flag;
   logic [2:0]     memory_bus;
   logic [1:0]     writeBack_bus;
   logic [1:0]     in_mem_size;
   logic           in_mem_unsigned;

   logic [LEN-1:0] out_read_data;
   logic [LEN-1:0] out_alu;
   logic [NB-1:0]  out_write_reg;
   logic [1:0]     writeBack_bus_out;
   logic           out_pc_src_branch;
   logic [LEN-1:0] out_pc_branch;
   logic           out_misaligned;

   modport master (
      output in_alu, in_reg2, in_write_reg, in_pc_branch, zero_flag,
             memory_bus, writeBack_bus, in_mem_size, in_mem_unsigned,
      input  out_read_data, out_alu, out_write_reg, writeBack_bus_out,
             out_pc_src_branch, out_pc_branch, out_misaligned
   );

   modport slave (
      input  in_alu, in_reg2, in_write_reg, in_pc_branch, zero_flag,
             memory_bus, writeBack_bus, in_mem_size, in_mem_unsigned,
      output out_read_data, out_alu, out_write_reg, writeBack_bus_out,
             out_pc_src_branch, out_pc_branch, out_misaligned
   );

endinterface

// File: rtl/memory_access_data_memory.sv
// Word-organised data memory: asynchronous read, synchronous byte-enabled write.
module data_memory #(
   parameter int unsigned LEN       = 32,
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [LEN/8-1:0]     be,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [LEN-1:0]       wdata,
   output logic [LEN-1:0]       rdata
);

   logic [LEN-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < int'(LEN / 8); i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/memory_access.sv
// MEM stage: loads/stores against the data memory, branch resolution and the
// MEM/WB pipeline register.
module memory_access
   import mips_pkg::*;
(
   input logic             clk,
   input logic             reset,
   memory_access_if.slave  bus
);

   mem_size_e      size;
   logic [1:0]     lane;
   logic           rd, wr, misaligned;
   logic           we;
   logic [LANES-1:0] be;
   logic [LEN-1:0] wdata, rdata, load_val;
   logic [7:0]     rd_byte;
   logic [15:0]    rd_half;

   assign size       = mem_size_e'(bus.in_mem_size);
   assign lane       = bus.in_alu[1:0];
   assign rd         = bus.memory_bus[MEM_READ];
   assign wr         = bus.memory_bus[MEM_WRITE];
   assign misaligned = (rd | wr) & is_misaligned(size, lane);
   assign we         = wr & ~misaligned & ~reset;

   // Byte enables and lane-replicated store data.
   always_comb begin
      be    = '0;
      wdata = bus.in_reg2;
      case (size)
         SIZE_BYTE: begin
            be    = LANES'(1) << lane;
            wdata = {4{bus.in_reg2[7:0]}};
         end
         SIZE_HALF: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{bus.in_reg2[15:0]}};
         end
         default: be = '1;
      endcase
   end

   data_memory #(
      .LEN       (LEN),
      .DEPTH     (MEM_DEPTH),
      .ADDR_BITS (ADDR_BITS)
   ) u_dmem (
      .clk   (clk),
      .we    (we),
      .be    (be),
      .addr  (bus.in_alu[ADDR_BITS+1:2]),
      .wdata (wdata),
      .rdata (rdata)
   );

   // Lane extraction and sign/zero extension of the old word contents.
   always_comb begin
      rd_byte  = 8'(rdata >> {lane, 3'b000});
      rd_half  = 16'(rdata >> {lane[1], 4'b0000});
      load_val = rdata;
      case (size)
         SIZE_BYTE: load_val = bus.in_mem_unsigned ? {24'b0, rd_byte}
                                                   : {{24{rd_byte[7]}}, rd_byte};
         SIZE_HALF: load_val = bus.in_mem_unsigned ? {16'b0, rd_half}
                                                   : {{16{rd_half[15]}}, rd_half};
         default:   load_val = rdata;
      endcase
   end

   assign bus.out_pc_src_branch = ~reset & bus.memory_bus[MEM_BRANCH] & bus.zero_flag;
   assign bus.out_pc_branch     = reset ? '0 : bus.in_pc_branch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_read_data     <= '0;
         bus.out_alu           <= '0;
         bus.out_write_reg     <= '0;
         bus.writeBack_bus_out <= '0;
         bus.out_misaligned    <= 1'b0;
      end else begin
         bus.out_read_data     <= (rd & ~misaligned) ? load_val : '0;
         bus.out_alu           <= bus.in_alu;
         bus.out_write_reg     <= bus.in_write_reg;
         bus.writeBack_bus_out <= bus.writeBack_bus;
         bus.out_misaligned    <= misaligned;
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Directed plus randomized check of memory_access against a byte-addressed
// reference memory model.
module tb_memory_access;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   memory_access_if bus ();

   memory_access dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int passed = 0;
   int total  = 0;
   byte unsigned ref_mem [4096];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic int size_bytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
      int n = size_bytes(sz);
      int base = int'(a[11:0]);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v |= 32'(ref_mem[(base + i) % 4096]) << (8 * i);
      if (!uns && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   // One MEM-stage operation: drive, check branch outputs, clock, check MEM/WB.
   task automatic op(input string tag, input bit rd, input bit wr, input logic [1:0] sz,
                     input bit uns, input logic [31:0] alu, input logic [31:0] reg2);
      int n = size_bytes(sz);
      bit mis = (rd || wr) && (int'(alu[1:0]) % n != 0);
      logic [31:0] exp_rd = (rd && !mis) ? ref_load(alu, sz, uns) : 32'h0;
      logic [1:0]  wb  = 2'($urandom);
      logic [4:0]  wr_reg = 5'($urandom);
      bit br = 1'($urandom);
      bit zf = 1'($urandom);
      logic [31:0] pcb = $urandom;
      bus.in_alu          = alu;
      bus.in_reg2         = reg2;
      bus.in_mem_size     = sz;
      bus.in_mem_unsigned = uns;
      bus.memory_bus      = {br, rd, wr};
      bus.zero_flag       = zf;
      bus.in_pc_branch    = pcb;
      bus.writeBack_bus   = wb;
      bus.in_write_reg    = wr_reg;
      #1;
      check({tag, ".pc_src"}, 32'(bus.out_pc_src_branch), 32'(br & zf));
      check({tag, ".pc_branch"}, bus.out_pc_branch, pcb);
      if (wr && !mis)
         for (int i = 0; i < n; i++)
            ref_mem[(int'(alu[11:0]) + i) % 4096] = 8'(reg2 >> (8 * i));
      @(posedge clk);
      #1;
      check({tag, ".read_data"}, bus.out_read_data, exp_rd);
      check({tag, ".misaligned"}, 32'(bus.out_misaligned), 32'(mis));
      check({tag, ".alu"}, bus.out_alu, alu);
      check({tag, ".wb"}, 32'(bus.writeBack_bus_out), 32'(wb));
      check({tag, ".write_reg"}, 32'(bus.out_write_reg), 32'(wr_reg));
   endtask

   initial begin
      reset = 1'b1;
      bus.in_alu = '0; bus.in_reg2 = '0; bus.in_write_reg = '0; bus.in_pc_branch = 32'h40;
      bus.zero_flag = 1'b1; bus.memory_bus = 3'b100; bus.writeBack_bus = '0;
      bus.in_mem_size = '0; bus.in_mem_unsigned = 1'b0;
      #1;
      check("rst.read_data", bus.out_read_data, 32'h0);
      check("rst.alu", bus.out_alu, 32'h0);
      check("rst.misaligned", 32'(bus.out_misaligned), 32'h0);
      check("rst.pc_src", 32'(bus.out_pc_src_branch), 32'h0);
      check("rst.pc_branch", bus.out_pc_branch, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("br.taken", 32'(bus.out_pc_src_branch), 32'h1);
      check("br.target", bus.out_pc_branch, 32'h40);
      bus.zero_flag = 1'b0;
      #1;
      check("br.not_taken", 32'(bus.out_pc_src_branch), 32'h0);
      @(posedge clk);
      #1;

      op("sw10", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
      op("lw10", 1, 0, 2'b10, 0, 32'h10, 32'h0);
      check("lw10.const", bus.out_read_data, 32'hDEADBEEF);
      op("lb13", 1, 0, 2'b00, 0, 32'h13, 32'h0);
      check("lb13.const", bus.out_read_data, 32'hFFFFFFDE);
      op("lbu13", 1, 0, 2'b00, 1, 32'h13, 32'h0);
      check("lbu13.const", bus.out_read_data, 32'h000000DE);
      op("lh10", 1, 0, 2'b01, 0, 32'h10, 32'h0);
      check("lh10.const", bus.out_read_data, 32'hFFFFBEEF);
      op("lhu12", 1, 0, 2'b01, 1, 32'h12, 32'h0);
      check("lhu12.const", bus.out_read_data, 32'h0000DEAD);
      op("sb11", 0, 1, 2'b00, 0, 32'h11, 32'h55);
      op("lw10b", 1, 0, 2'b10, 0, 32'h10, 32'h0);
      check("lw10b.const", bus.out_read_data, 32'hDEAD55EF);
      op("sw12mis", 0, 1, 2'b10, 0, 32'h12, 32'h12345678);
      check("sw12mis.flag", 32'(bus.out_misaligned), 32'h1);
      op("lw10c", 1, 0, 2'b10, 0, 32'h10, 32'h0);
      check("lw10c.const", bus.out_read_data, 32'hDEAD55EF);
      check("lw10c.mis_clear", 32'(bus.out_misaligned), 32'h0);
      op("lh11mis", 1, 0, 2'b01, 0, 32'h11, 32'h0);
      check("lh11mis.flag", 32'(bus.out_misaligned), 32'h1);
      op("rw_same", 1, 1, 2'b10, 0, 32'h10, 32'h0BADF00D);
      check("rw_same.old", bus.out_read_data, 32'hDEAD55EF);
      op("sw1000", 0, 1, 2'b10, 0, 32'h1000, 32'hCAFEF00D);
      op("lw0", 1, 0, 2'b10, 0, 32'h0, 32'h0);
      check("lw0.wrap", bus.out_read_data, 32'hCAFEF00D);

      bus.in_alu = 32'h7; bus.in_reg2 = 32'h0; bus.in_mem_size = 2'b10;
      bus.memory_bus = 3'b000; bus.writeBack_bus = 2'b10; bus.in_write_reg = 5'd5;
      @(posedge clk);
      #1;
      check("pass.alu", bus.out_alu, 32'h7);
      check("pass.wb", 32'(bus.writeBack_bus_out), 32'h2);
      check("pass.write_reg", 32'(bus.out_write_reg), 32'h5);
      check("pass.read_data", bus.out_read_data, 32'h0);

      // Mid-cycle asynchronous reset with nonzero registered outputs.
      op("lw_pre_rst", 1, 0, 2'b10, 0, 32'h10, 32'h0);
      bus.memory_bus = 3'b100; bus.zero_flag = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      check("mrst.read_data", bus.out_read_data, 32'h0);
      check("mrst.alu", bus.out_alu, 32'h0);
      check("mrst.write_reg", 32'(bus.out_write_reg), 32'h0);
      check("mrst.wb", 32'(bus.writeBack_bus_out), 32'h0);
      check("mrst.misaligned", 32'(bus.out_misaligned), 32'h0);
      check("mrst.pc_src", 32'(bus.out_pc_src_branch), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Seed a small region, then random traffic with random upper address bits.
      for (int w = 0; w < 16; w++)
         op("seed", 0, 1, 2'b10, 0, 32'h100 + 32'(4 * w), $urandom);
      for (int k = 0; k < 300; k++) begin
         logic [31:0] a = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
         op("rand", 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage of the 5-stage MIPS pipeline. It consumes the EX/MEM outputs of execute: ALU result, store data, destination register, branch target and flags, plus the memory and writeBack control buses.
- It performs loads and stores against an internal word-organised data memory and resolves conditional branches back to instruction_fetch.
- It registers the MEM/WB pipeline register that feeds the write-back stage and the decode register file.

Parameters:
- LEN, 32, datapath width.
- NB, $clog2(LEN), register-index width (5).
- MEM_DEPTH, 1024, data memory depth in LEN-bit words.
- ADDR_BITS, $clog2(MEM_DEPTH), word-index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears pipeline state.
- in_alu  in  LEN  ALU result; byte address for loads and stores, passthrough value otherwise.
- in_reg2  in  LEN  store data (rt).
- in_write_reg  in  NB  destination register index.
- in_pc_branch  in  LEN  computed branch target.
- zero_flag  in  1  ALU zero.
- memory_bus  in  3  [2]=branch, [1]=mem_read, [0]=mem_write.
- writeBack_bus  in  2  [1]=RegWrite, [0]=MemtoReg; passed through to WB.
- in_mem_size  in  2  00=byte, 01=halfword, 10=word, 11=reserved (treated as word).
- in_mem_unsigned  in  1  1 = zero-extend loads (lbu/lhu).
- out_read_data  out  LEN  registered, extended load data.
- out_alu  out  LEN  registered in_alu.
- out_write_reg  out  NB  registered in_write_reg.
- writeBack_bus_out  out  2  registered writeBack_bus.
- out_pc_src_branch  out  1  combinational branch-taken to instruction_fetch.
- out_pc_branch  out  LEN  combinational passthrough of in_pc_branch.
- out_misaligned  out  1  registered; access in the previous cycle was misaligned.

Behaviour:
- Reset values: out_read_data, out_alu, out_write_reg, writeBack_bus_out and out_misaligned are all 0. Reset asserted mid-operation clears these immediately, asynchronously.
- Data memory contents are not reset. They are zero-initialised at configuration only.
- Branch resolution is combinational, with no latency: out_pc_src_branch = memory_bus[2] & zero_flag, and out_pc_branch = in_pc_branch. Both are forced 0 while reset is high.
- Addressing: word index = in_alu[ADDR_BITS+1:2]. Upper address bits are ignored, so the address wraps modulo MEM_DEPTH words. Lane select uses in_alu[1:0].
- Alignment: a halfword access needs in_alu[0]=0; a word access needs in_alu[1:0]=00. Byte accesses are always aligned.
- Stores (mem_write=1, aligned): the memory updates at the rising edge with per-byte write enables.
  - byte: in_reg2[7:0] goes to lane in_alu[1:0].
  - halfword: in_reg2[15:0] goes to lanes {in_alu[1],0} and {in_alu[1],1}.
  - word: all four lanes.
  - Little-endian: lane 0 = bits [7:0].
- Loads (mem_read=1, aligned): the memory is read in the same cycle and the extracted, extended value is registered into out_read_data at the rising edge. Latency is 1 cycle, aligned with out_alu and writeBack_bus_out.
  - byte: the selected lane, sign- or zero-extended per in_mem_unsigned.
  - halfword: the selected half, extended the same way.
  - word: as is.
- When mem_read=0, out_read_data is registered as 0.
- mem_read and mem_write both set: the write is performed, and the read returns pre-write (old) contents (read-before-write).
- Misaligned access: the write is suppressed, out_read_data is 0, and out_misaligned is 1 for one cycle. writeBack_bus_out still passes through unchanged; squashing is the hazard unit's job.
- No stall or flush ports. The MEM/WB register loads every cycle.

Decomposition:
- Shared package mips_pkg holds:
  - memory_bus bit positions (MEM_BRANCH=2, MEM_READ=1, MEM_WRITE=0);
  - writeBack bit positions (WB_REGWRITE=1, WB_MEMTOREG=0);
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD.
- One sub-module: data_memory. It is a LEN-wide, MEM_DEPTH-deep array with an asynchronous-read port, a synchronous write port and a 4-bit byte enable. Lane extraction, extension and the MEM/WB register live in memory_access.

Test Plan:
- Reset: assert reset mid-cycle with nonzero outputs → all registered outputs 0 immediately; out_pc_src_branch=0.
- Word store/load: sw 0xDEADBEEF at addr 0x10, then lw at 0x10 → out_read_data=0xDEADBEEF one cycle after the load; out_misaligned=0.
- Byte/half extend: after the word above, lb addr 0x13 → 0xFFFFFFDE; lbu 0x13 → 0x000000DE; lh 0x10 → 0xFFFFBEEF; lhu 0x12 → 0x0000DEAD.
- Partial store: sb 0x55 at addr 0x11, then lw 0x10 → 0xDEAD55EF.
- Misaligned: sw at addr 0x12 with in_reg2=0x12345678 → no write (lw 0x10 still 0xDEAD55EF); out_misaligned=1 for exactly one cycle. lh at 0x11 → out_read_data=0, out_misaligned=1.
- Branch and wrap-around:
  - memory_bus=100, zero_flag=1, in_pc_branch=0x40 → out_pc_src_branch=1, out_pc_branch=0x40 in the same cycle; zero_flag=0 → 0.
  - sw at addr 0x1000 (MEM_DEPTH=1024) aliases word 0 → lw at 0x0 returns the stored value.
  - Passthrough: in_alu=0x7, writeBack_bus=10, in_write_reg=5 with no memory op → next cycle out_alu=0x7, writeBack_bus_out=10, out_write_reg=5, out_read_data=0.
